// File: rtl/dp_pkg.sv
// Shared sizing for the dot-product operand bus (feeder and consumer).
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package dp_pkg;

  localparam int PIXEL_N     = 785;
  localparam int PIXEL_SIZE  = 10;
  localparam int WEIGHT_SIZE = 19;
  localparam int PARALLEL    = 4;
  localparam int BUS_WIDTH   = 7;

  // Beats needed to carry one vector across all lanes (last beat may be partial).
  function automatic int BEATS_PER_VEC(input int pixel_n, input int parallel);
    return (pixel_n + parallel - 1) / parallel;
  endfunction

  // Buses needed to carry one vector (last bus may be partially filled).
  function automatic int BUSES_PER_VEC(input int beats, input int bus_width);
    return (beats + bus_width - 1) / bus_width;
  endfunction

endpackage

// File: rtl/dpf_pack_buf.sv
// Fill buffer: writes one beat per slot, zeroes tail lanes on a vector's last beat, flags completion.
// Latency: a completing beat is visible on pix_view/wgt_view combinationally in its own cycle.
// Backpressure: full stays set until clr; the owner must not write while full.
module dpf_pack_buf #(
  parameter int PARALLEL    = dp_pkg::PARALLEL,
  parameter int BUS_WIDTH   = dp_pkg::BUS_WIDTH,
  parameter int PIXEL_SIZE  = dp_pkg::PIXEL_SIZE,
  parameter int WEIGHT_SIZE = dp_pkg::WEIGHT_SIZE,
  parameter int TAIL_LANES  = dp_pkg::PIXEL_N % dp_pkg::PARALLEL
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       wr,
  input  logic                                       last,
  input  logic [PARALLEL*PIXEL_SIZE-1:0]             in_pixel,
  input  logic [PARALLEL*WEIGHT_SIZE-1:0]            in_weight,
  input  logic                                       clr,
  output logic                                       full,
  output logic                                       done,
  output logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]   pix_view,
  output logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0]  wgt_view
);
  import dp_pkg::*;

  localparam int SW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH + 1) : 1;

  logic [SW-1:0]                              slot;
  logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]   pix_buf;
  logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0]  wgt_buf;
  logic                                       completes;

  assign completes = wr && (last || (slot == SW'(BUS_WIDTH - 1)));
  assign done      = full || completes;

  // Buffer image with the current beat merged in, so a completing beat can swap out this cycle.
  always_comb begin
    pix_view = pix_buf;
    wgt_view = wgt_buf;
    if (wr) begin
      for (int j = 0; j < PARALLEL; j++) begin
        for (int w = 0; w < BUS_WIDTH; w++) begin
          if (slot == SW'(w)) begin
            if (last && (TAIL_LANES != 0) && (j >= TAIL_LANES)) begin
              pix_view[(j*BUS_WIDTH+w)*PIXEL_SIZE +: PIXEL_SIZE]   = '0;
              wgt_view[(j*BUS_WIDTH+w)*WEIGHT_SIZE +: WEIGHT_SIZE] = '0;
            end else begin
              pix_view[(j*BUS_WIDTH+w)*PIXEL_SIZE +: PIXEL_SIZE]   = in_pixel[j*PIXEL_SIZE +: PIXEL_SIZE];
              wgt_view[(j*BUS_WIDTH+w)*WEIGHT_SIZE +: WEIGHT_SIZE] = in_weight[j*WEIGHT_SIZE +: WEIGHT_SIZE];
            end
          end
        end
      end
    end
  end

  // Clear on swap takes priority; otherwise absorb the beat and latch completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_buf <= '0;
      wgt_buf <= '0;
      slot    <= '0;
      full    <= 1'b0;
    end else if (clr) begin
      pix_buf <= '0;
      wgt_buf <= '0;
      slot    <= '0;
      full    <= 1'b0;
    end else if (wr) begin
      pix_buf <= pix_view;
      wgt_buf <= wgt_view;
      slot    <= slot + 1'b1;
      full    <= completes;
    end
  end

endmodule

// File: rtl/dp_operand_feeder.sv
// Packs pixel/weight beats into lane-major buses held for one BUS_WIDTH-cycle window (DPF_BUBBLE_CNT_EN adds bubble_count).
// Latency: a beat shows from the next phase 0; at most 2*BUS_WIDTH cycles from a bus's first beat.
// Backpressure: in_ready drops while the fill buffer is full, until the next phase wrap swaps it out.
module dp_operand_feeder #(
  parameter int PIXEL_N     = dp_pkg::PIXEL_N,
  parameter int PIXEL_SIZE  = dp_pkg::PIXEL_SIZE,
  parameter int WEIGHT_SIZE = dp_pkg::WEIGHT_SIZE,
  parameter int PARALLEL    = dp_pkg::PARALLEL,
  parameter int BUS_WIDTH   = dp_pkg::BUS_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       GlobalReset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [PARALLEL*PIXEL_SIZE-1:0]             in_pixel,
  input  logic [PARALLEL*WEIGHT_SIZE-1:0]            in_weight,
  output logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]   Pixels,
  output logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0]  Weights,
  output logic                                       bus_valid,
  output logic                                       vec_first,
  output logic                                       vec_last,
  output logic                                       vec_done,
  output logic [$clog2(BUS_WIDTH)-1:0]               phase
`ifdef DPF_BUBBLE_CNT_EN
  , output logic [15:0]                              bubble_count
`endif
);
  import dp_pkg::*;

  localparam int N_BEATS    = BEATS_PER_VEC(PIXEL_N, PARALLEL);
  localparam int N_BUSES    = BUSES_PER_VEC(N_BEATS, BUS_WIDTH);
  localparam int TAIL_LANES = PIXEL_N % PARALLEL;
  localparam int PW         = $clog2(BUS_WIDTH);
  localparam int BTW        = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int BSW        = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;

  logic [BTW-1:0]                             beat_cnt;
  logic [BSW-1:0]                             bus_cnt;
  logic                                       accept;
  logic                                       last_beat;
  logic                                       wrap;
  logic                                       emit;
  logic                                       buf_full;
  logic                                       buf_done;
  logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]   pix_view;
  logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0]  wgt_view;

  // Ready is gated by reset directly so it reads 0 while reset is held.
  assign in_ready  = GlobalReset && !buf_full;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == BTW'(N_BEATS - 1));
  assign wrap      = (phase == PW'(BUS_WIDTH - 1));
  assign emit      = wrap && buf_done;
  assign vec_done  = wrap && vec_last && bus_valid;

  dpf_pack_buf #(
    .PARALLEL    (PARALLEL),
    .BUS_WIDTH   (BUS_WIDTH),
    .PIXEL_SIZE  (PIXEL_SIZE),
    .WEIGHT_SIZE (WEIGHT_SIZE),
    .TAIL_LANES  (TAIL_LANES)
  ) u_buf (
    .clk       (clk),
    .rst_n     (GlobalReset),
    .wr        (accept),
    .last      (last_beat),
    .in_pixel  (in_pixel),
    .in_weight (in_weight),
    .clr       (emit),
    .full      (buf_full),
    .done      (buf_done),
    .pix_view  (pix_view),
    .wgt_view  (wgt_view)
  );

  // Free-running slot index shared with the consumer.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset)  phase <= '0;
    else if (wrap)     phase <= '0;
    else               phase <= phase + 1'b1;
  end

  // Beat position within the vector; bus index of the bus currently held in the fill buffer.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      beat_cnt <= '0;
      bus_cnt  <= '0;
    end else begin
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (emit)   bus_cnt  <= (bus_cnt == BSW'(N_BUSES - 1)) ? '0 : bus_cnt + 1'b1;
    end
  end

  // Output registers change only on the phase wrap: a completed bus, or an all-zero bubble.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      Pixels    <= '0;
      Weights   <= '0;
      bus_valid <= 1'b0;
      vec_first <= 1'b0;
      vec_last  <= 1'b0;
    end else if (wrap) begin
      if (buf_done) begin
        Pixels    <= pix_view;
        Weights   <= wgt_view;
        bus_valid <= 1'b1;
        vec_first <= (bus_cnt == '0);
        vec_last  <= (bus_cnt == BSW'(N_BUSES - 1));
      end else begin
        Pixels    <= '0;
        Weights   <= '0;
        bus_valid <= 1'b0;
        vec_first <= 1'b0;
        vec_last  <= 1'b0;
      end
    end
  end

`ifdef DPF_BUBBLE_CNT_EN
  // Saturating count of wrap edges that emitted a bubble.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset)                              bubble_count <= '0;
    else if (wrap && !buf_done && (bubble_count != 16'hFFFF)) bubble_count <= bubble_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_dp_operand_feeder.sv
module tb_dp_operand_feeder;
  localparam int PN    = 785;
  localparam int PS    = 10;
  localparam int WS    = 19;
  localparam int PL    = 4;
  localparam int BW    = 7;
  localparam int NBEAT = (PN + PL - 1) / PL;     // 197
  localparam int NBUS  = (NBEAT + BW - 1) / BW;  // 29
  localparam int PXW   = BW * PL * PS;
  localparam int WTW   = BW * PL * WS;

  logic                clk = 1'b0;
  logic                GlobalReset = 1'b0;
  logic                in_valid = 1'b0;
  logic [PL*PS-1:0]    in_pixel = '0;
  logic [PL*WS-1:0]    in_weight = '0;
  logic                in_ready;
  logic [PXW-1:0]      Pixels;
  logic [WTW-1:0]      Weights;
  logic                bus_valid, vec_first, vec_last, vec_done;
  logic [2:0]          phase;
`ifdef DPF_BUBBLE_CNT_EN
  logic [15:0]         bubble_count;
`endif

  dp_operand_feeder dut (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_weight(in_weight), .Pixels(Pixels), .Weights(Weights),
    .bus_valid(bus_valid), .vec_first(vec_first), .vec_last(vec_last),
    .vec_done(vec_done), .phase(phase)
`ifdef DPF_BUBBLE_CNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [WTW-1:0] act, input logic [WTW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: beats grouped into whole buses by element index.
  typedef struct { logic [PXW-1:0] pix; logic [WTW-1:0] wgt; bit first; bit last; } bus_t;
  bus_t           exp_q[$];
  longint         dot_q[$];
  int             m_beat;
  logic [PXW-1:0] m_pix;
  logic [WTW-1:0] m_wgt;
  longint         m_dot;

  task automatic model_accept(input logic [PL*PS-1:0] p, input logic [PL*WS-1:0] w);
    int     bus  = m_beat / BW;
    int     slot = m_beat % BW;
    longint a, b;
    bus_t   nb;
    for (int j = 0; j < PL; j++) begin
      if (m_beat * PL + j < PN) begin
        m_pix[(j*BW+slot)*PS +: PS] = p[j*PS +: PS];
        m_wgt[(j*BW+slot)*WS +: WS] = w[j*WS +: WS];
        a = p[j*PS +: PS];
        b = w[j*WS +: WS];
        m_dot += a * b;
      end
    end
    if (slot == BW - 1 || m_beat == NBEAT - 1) begin
      nb.pix = m_pix; nb.wgt = m_wgt; nb.first = (bus == 0); nb.last = (bus == NBUS - 1);
      exp_q.push_back(nb);
      m_pix = '0; m_wgt = '0;
    end
    if (m_beat == NBEAT - 1) begin
      dot_q.push_back(m_dot);
      m_dot = 0;
      m_beat = 0;
    end else begin
      m_beat++;
    end
  endtask

  // Monitor: window contents, hold stability, bubbles, vec_done and the consumer-side dot product.
  int             cyc, vwin, bub, pend, tot_bub, ndone;
  bit             seen_v;
  logic [PXW-1:0] h_pix, tail_pix;
  logic [WTW-1:0] h_wgt, tail_wgt;
  logic [2:0]     h_flags;
  longint         acc, pa, wa;
  bus_t           m_e;

  always @(negedge clk) begin
    if (!GlobalReset) begin
      cyc = 0;
    end else begin
      chk("phase", phase, cyc % BW);
      if (cyc % BW == 0) begin
        h_pix = Pixels; h_wgt = Weights; h_flags = {bus_valid, vec_first, vec_last};
        if (bus_valid) begin
          vwin++;
          if (seen_v) bub += pend;
          pend = 0;
          seen_v = 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_window", 1, 0);
          end else begin
            m_e = exp_q.pop_front();
            chk_wide("win_pix", WTW'(Pixels), WTW'(m_e.pix));
            chk_wide("win_wgt", Weights, m_e.wgt);
            chk("win_first_last", {vec_first, vec_last}, {m_e.first, m_e.last});
          end
          if (vec_first) acc = 0;
          for (int j = 0; j < PL; j++) begin
            for (int w = 0; w < BW; w++) begin
              pa = Pixels[(j*BW+w)*PS +: PS];
              wa = Weights[(j*BW+w)*WS +: WS];
              acc += pa * wa;
            end
          end
          if (vec_last) begin
            tail_pix = Pixels; tail_wgt = Weights;
            if (dot_q.size() == 0) chk("dot_missing", 1, 0);
            else chk("dot_product", acc, dot_q.pop_front());
          end
        end else begin
          if (cyc >= BW) begin pend++; tot_bub++; end
          chk("bubble_zero", {Pixels != '0, Weights != '0, vec_first, vec_last}, 0);
        end
`ifdef DPF_BUBBLE_CNT_EN
        chk("bubble_count", bubble_count, tot_bub);
`endif
      end else begin
        chk("hold", {Pixels !== h_pix, Weights !== h_wgt, {bus_valid, vec_first, vec_last} !== h_flags}, 0);
      end
      chk("vec_done", vec_done, (cyc % BW == BW - 1) && h_flags[2] && h_flags[0]);
      if (vec_done) ndone++;
      cyc++;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    GlobalReset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete(); dot_q.delete();
    m_beat = 0; m_pix = '0; m_wgt = '0; m_dot = 0; tot_bub = 0; acc = 0;
    vwin = 0; bub = 0; pend = 0; seen_v = 0; ndone = 0;
    GlobalReset = 1'b1;
  endtask

  task automatic send_beat(input logic [PL*PS-1:0] p, input logic [PL*WS-1:0] w);
    bit ok = 0;
    in_valid = 1'b1; in_pixel = p; in_weight = w;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) model_accept(p, w);
    else chk("send_timeout", 0, 1);
  endtask

  task automatic gen_beat(input int b, input int patt, output logic [PL*PS-1:0] p, output logic [PL*WS-1:0] w);
    for (int j = 0; j < PL; j++) begin
      if (patt == 0) begin
        p[j*PS +: PS] = PS'(b + j);
        w[j*WS +: WS] = WS'(1);
      end else begin
        p[j*PS +: PS] = PS'($urandom);
        w[j*WS +: WS] = WS'($urandom);
      end
    end
  endtask

  task automatic run_scn(input int nbeats, input int start, input int stall_beat,
                         input int stall_len, input int patt, input bit rand_idle);
    logic [PL*PS-1:0] p;
    logic [PL*WS-1:0] w;
    do_reset();
    repeat (start) begin @(posedge clk); #1; end
    for (int b = 0; b < nbeats; b++) begin
      if (b == stall_beat) repeat (stall_len) begin @(posedge clk); #1; end
      if (rand_idle && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      gen_beat(b, patt, p, w);
      send_beat(p, w);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (2 * BW) @(posedge clk);
    #1;
  endtask

  typedef struct { int nbeats; int start; int stall_beat; int stall_len; int patt; int exp_win; int exp_bub; } scn_t;
  scn_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{197, 0,  -1, 0, 0, 29, 0};  // continuous from phase 0, incrementing data
    tbl[1] = '{197, 0,  10, 3, 1, 29, 1};  // 3-cycle stall inside bus 1
    tbl[2] = '{394, 0,  -1, 0, 1, 58, 0};  // back-to-back vectors
    tbl[3] = '{197, 3,  -1, 0, 1, 29, 0};  // stream starts mid-window
    tbl[4] = '{197, 0, 196, 4, 1, 29, 0};  // stall before the single-beat last bus
    tbl[5] = '{197, 0,  14, 7, 1, 29, 1};  // whole-window stall at a bus boundary
    tbl[6] = '{197, 0,  20, 2, 1, 29, 1};  // stall before the final slot of a bus

    // Reset held: everything quiet, source not accepted.
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {Pixels != '0, Weights != '0, bus_valid, vec_first, vec_last, vec_done}, 0);
    chk("rst_phase", phase, 0);
    do_reset();
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 2 * BW; i++) begin
      @(negedge clk);
      chk("idle_phase", phase, i % BW);
      chk("idle_valid_ready", {bus_valid, in_ready}, 2'b01);
    end

    for (int i = 0; i < 7; i++) begin
      run_scn(tbl[i].nbeats, tbl[i].start, tbl[i].stall_beat, tbl[i].stall_len, tbl[i].patt, 1'b0);
      chk($sformatf("scn%0d_windows", i), vwin, tbl[i].exp_win);
      chk($sformatf("scn%0d_bubbles", i), bub, tbl[i].exp_bub);
      chk($sformatf("scn%0d_vec_done", i), ndone, tbl[i].nbeats / NBEAT);
      chk($sformatf("scn%0d_dot_left", i), dot_q.size(), 0);
      if (i == 0) begin
        chk_wide("tail_pix", WTW'(tail_pix), WTW'(196));
        chk_wide("tail_wgt", tail_wgt, WTW'(1));
      end
    end

    // Reset mid-vector: outputs drop at once, then a fresh vector gives exactly 29 windows.
    do_reset();
    begin
      logic [PL*PS-1:0] p;
      logic [PL*WS-1:0] w;
      for (int b = 0; b < 100; b++) begin
        gen_beat(b, 1, p, w);
        send_beat(p, w);
      end
    end
    chk("pre_reset_valid", bus_valid, 1);
    #1 GlobalReset = 1'b0;
    #1;
    chk("midrst_outputs", {Pixels != '0, Weights != '0, bus_valid, vec_first, vec_last, vec_done, in_ready}, 0);
    chk("midrst_phase", phase, 0);
    run_scn(197, 0, -1, 0, 1, 1'b0);
    chk("midrst_windows", vwin, 29);
    chk("midrst_bubbles", bub, 0);

    // Randomized source gaps and data across two vectors.
    run_scn(394, $urandom_range(0, BW - 1), -1, 0, 1, 1'b1);
    chk("rand_windows", vwin, 58);
    chk("rand_vec_done", ndone, 2);
    chk("rand_dot_left", dot_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_operand_feeder.md
# dp_operand_feeder

Producer side of the dot-product operand bus. Accepts pixel/weight beats (one word per parallel lane per beat) over a valid/ready stream, packs them into the lane-major `Pixels`/`Weights` buses consumed by the dot-product unit, and holds each bus stable for exactly one `BUS_WIDTH`-cycle window aligned to the consumer's slot counter. It zero-pads the tail of every `PIXEL_N`-element vector and marks vector boundaries, so each neuron's accumulation sees exactly `PIXEL_N` products.

## Interface
- `PIXEL_N`, 785: elements per vector (one neuron).
- `PIXEL_SIZE`, 10: pixel word width.
- `WEIGHT_SIZE`, 19: weight word width.
- `PARALLEL`, 4: lanes.
- `BUS_WIDTH`, 7: slots per lane per bus; also the bus hold window in cycles.
- `clk` in 1: clock, rising edge.
- `GlobalReset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_pixel` in `PARALLEL*PIXEL_SIZE`: lane j at bits `[j*PIXEL_SIZE +: PIXEL_SIZE]`.
- `in_weight` in `PARALLEL*WEIGHT_SIZE`: lane j at bits `[j*WEIGHT_SIZE +: WEIGHT_SIZE]`.
- `Pixels` out `BUS_WIDTH*PARALLEL*PIXEL_SIZE`: lane j, slot w at bits `[(j*BUS_WIDTH+w)*PIXEL_SIZE +: PIXEL_SIZE]`.
- `Weights` out `BUS_WIDTH*PARALLEL*WEIGHT_SIZE`: same packing.
- `bus_valid` out 1: the current window carries data; when low, both buses are all-zero.
- `vec_first` out 1: the current bus is the first of a vector.
- `vec_last` out 1: the current bus is the last of a vector.
- `vec_done` out 1: one-cycle pulse in the final cycle of a `vec_last` window.
- `phase` out `$clog2(BUS_WIDTH)`: slot index; equals the consumer's slot counter.
- `bubble_count` out 16: only present with `DPF_BUBBLE_CNT_EN`.

## Operation
- Derived constants:
  - `BEATS_PER_VEC = ceil(PIXEL_N/PARALLEL)`, which is 197 with the defaults.
  - `TAIL_LANES = PIXEL_N mod PARALLEL`, which is 1; a value of 0 means the last beat is full.
  - `BUSES_PER_VEC = ceil(BEATS_PER_VEC/BUS_WIDTH)`, which is 29.
- `phase` is free-running, 0..`BUS_WIDTH`-1 with wrap. It is 0 in the first cycle after reset, matching the consumer.
- **Fill buffer.** Beat `b` within the current bus writes slot `b` of every lane.
  - On the last beat of a vector, lanes ≥ `TAIL_LANES` are forced to zero, unless `TAIL_LANES` is 0.
  - The bus completes when slot `BUS_WIDTH-1` is written, or when the vector's last beat is written. Unwritten slots stay zero.
  - A completed buffer sets `full`.
  - `in_ready = !full`.
- **Swap.** On the edge ending `phase == BUS_WIDTH-1`:
  - If `full`, or the bus completes in that same cycle, the output registers load the fill buffer and its flags, `bus_valid` goes to 1, and the fill buffer and `full` clear.
  - Otherwise the outputs load zero with `bus_valid = 0` (a bubble). A partial fill is retained, not emitted.
- **Counters.**
  - `beat_cnt` runs 0..`BEATS_PER_VEC`-1. It wraps after the vector's last beat.
  - `bus_cnt` runs 0..`BUSES_PER_VEC`-1. It drives `vec_first` (bus_cnt == 0) and `vec_last` (final bus).
- **Reset.** `GlobalReset` low at any time, including mid-vector, clears everything immediately: `phase`, counters, fill buffer, `full`, all outputs 0, `in_ready` 0. `in_ready` rises in the first cycle after deassertion.

## Timing
- Sustained throughput is one beat per cycle with zero bubbles when beats arrive continuously starting at phase 0.
- A beat accepted at phase `p` appears on the bus from the next `phase == 0` through `phase == BUS_WIDTH-1`.
- Worst-case latency is `2*BUS_WIDTH` cycles, from the first beat of a bus to its presentation.
- The bus, `bus_valid`, `vec_first` and `vec_last` change only on the `phase` wrap edge.
- `vec_done` is high only while `phase == BUS_WIDTH-1 && vec_last && bus_valid`.
- When `full` is set, `in_ready` is low from the next cycle until the swap edge; a `full` buffer always swaps at that edge.

## Configuration
- `DPF_BUBBLE_CNT_EN`:
  - Defined: `bubble_count` increments, saturating at 0xFFFF, on every swap edge that emits a bubble; it resets to 0.
  - Undefined: neither the port nor the counter exists, and behaviour is otherwise identical.

## Structure
- Shared package `dp_pkg` holds the default sizes (`PIXEL_N`, `PIXEL_SIZE`, `WEIGHT_SIZE`, `PARALLEL`, `BUS_WIDTH`) and the `BEATS_PER_VEC`/`BUSES_PER_VEC` functions, all shared with the dot-product unit.
- One sub-module, `dpf_pack_buf`: the fill buffer with slot write, tail-lane masking, `full` flag and clear-on-swap. Counters, swap control and output registers stay in the top level.

## Test plan
- **Reset, no input:** release reset → `phase` cycles 0..6, `bus_valid` = 0, buses all-zero, `in_ready` = 1.
- **Continuous stream:** drive 197 beats from phase 0, lane j word = beat index + j, weights = 1 → 29 consecutive valid windows with zero bubbles.
  - `vec_first` on window 0; `vec_last` and `vec_done` on window 28.
  - Window 28 slot 0 lane 0 = 196; its other lanes and slots are 0.
- **Stalled source:** `in_valid` low for 3 cycles inside a bus → a bubble window is inserted; data order is preserved. With the macro defined, `bubble_count` = 1.
- **Back-to-back vectors:** 394 beats → the second vector starts with `vec_first` in the window immediately after the first `vec_done`.
- **Reset mid-vector:** assert reset at beat 100 → all outputs 0 at once. After release, a new 197-beat vector produces exactly 29 windows.
- **Golden dot product:** connect the feeder to the dot-product unit with random operands → the consumer sum equals the software dot product over 785 elements.
